// File: rtl/hex_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with guard interval and frame-synchronous load.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  load,
  output logic                  busy,
  output logic                  frame_start,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  logic [CNT_W-1:0]    r_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [4*DIGITS-1:0] r_pd_val;
  logic [DIGITS-1:0]   r_pd_dp;
  logic                r_pend_valid;
  logic [4*DIGITS-1:0] r_sh_val;
  logic [DIGITS-1:0]   r_sh_dp;
  logic                r_busy;
  logic                r_frame_start;
  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_an;

  logic                w_slot_end;
  logic                w_frame_end;
  logic                w_guard;
  logic [3:0]          w_nib;
  logic                w_dp_cur;
  logic                w_blank_cur;
  logic [DIGITS-1:0]   w_blank;
  logic [DIGITS-1:0]   w_an_dig;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);

  generate
    if (GUARD == 0) begin : g_noguard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_cnt < CNT_W'(GUARD));
    end
  endgenerate

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank only while every digit above it (and itself) is a zero without dp.
  function automatic logic [DIGITS-1:0] lead_blank(input logic [4*DIGITS-1:0] v,
                                                   input logic [DIGITS-1:0]   d);
    logic run;
    run        = 1'b1;
    lead_blank = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run           = run && (v[4*i +: 4] == 4'h0) && !d[i];
      lead_blank[i] = run;
    end
  endfunction

  assign w_blank = lead_blank(r_sh_val, r_sh_dp);
`else
  assign w_blank = '0;
`endif

  always_comb begin
    w_nib       = 4'h0;
    w_dp_cur    = 1'b0;
    w_blank_cur = 1'b0;
    w_an_dig    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_nib       = r_sh_val[4*i +: 4];
        w_dp_cur    = r_sh_dp[i];
        w_blank_cur = w_blank[i];
        w_an_dig[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pd_val      <= '0;
      r_pd_dp       <= '0;
      r_pend_valid  <= 1'b0;
      r_sh_val      <= '0;
      r_sh_dp       <= '0;
      r_busy        <= 1'b0;
      r_frame_start <= 1'b0;
      r_seg         <= 8'hFF;
      r_an          <= '1;
    end else begin
      r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
      // Transfer sees pre-edge pending; a same-edge load lands in pending afterwards.
      if (w_frame_end && r_pend_valid) begin
        r_sh_val     <= r_pd_val;
        r_sh_dp      <= r_pd_dp;
        r_pend_valid <= 1'b0;
      end
      if (load) begin
        r_pd_val     <= value;
        r_pd_dp      <= dp;
        r_pend_valid <= 1'b1;
      end
      r_busy        <= r_pend_valid;
      r_frame_start <= (r_cnt == '0) && (r_idx == '0);
      r_an          <= w_guard ? '1 : w_an_dig;
      r_seg         <= w_blank_cur ? 8'hFF : {~w_dp_cur, hex_to_seg(w_nib)};
    end
  end

  assign busy        = r_busy;
  assign frame_start = r_frame_start;
  assign seg         = r_seg;
  assign an          = r_an;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: a time-based reference model predicts every output cycle.
module tb_hex_scan_display;
  localparam int D  = 4;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int FR = D * R;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        busy;
  logic        frame_start;
  logic [7:0]  seg;
  logic [3:0]  an;

  always #5 clk = ~clk;

  hex_scan_display #(.DIGITS(D), .REFRESH_DIV(R), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .load(load),
    .busy(busy), .frame_start(frame_start), .seg(seg), .an(an)
  );

  typedef struct {
    logic [7:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       fs;
    int         t;
  } exp_t;

  typedef struct {
    int          tgt;
    logic [15:0] v;
    logic [3:0]  d;
  } ld_t;

  exp_t sb[$];
  ld_t  hist[$];
  int   mdl_t = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t mon_e;

  logic [7:0] CODES [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Output time t = cycles since reset release; a load at time t is shown from frame (t+1)/FR + 1.
  function automatic exp_t model(input int t);
    exp_t e;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  nib;
    int f, idx, cnt;
    f   = t / FR;
    idx = (t / R) % D;
    cnt = t % R;
    v   = '0;
    d   = '0;
    foreach (hist[k]) begin
      if (hist[k].tgt <= f) begin
        v = hist[k].v;
        d = hist[k].d;
      end
    end
    e.t    = t;
    e.fs   = (t % FR == 0);
    e.busy = (hist.size() > 0) && (hist[hist.size()-1].tgt * FR > t);
    e.an   = (cnt < G) ? 4'hF : ~(4'b0001 << idx);
    nib    = v[4*idx +: 4];
    e.seg  = CODES[nib] & (d[idx] ? 8'h7F : 8'hFF);
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic blank;
      blank = (idx > 0);
      for (int j = idx; j < D; j++) begin
        if (v[4*j +: 4] != 4'h0 || d[j]) blank = 1'b0;
      end
      if (blank) e.seg = 8'hFF;
    end
`endif
    return e;
  endfunction

  task automatic chk(input string nm, input int t, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%02h exp=%02h", nm, t, got, exp);
    end
  endtask

  // Monitor: every output cycle with a prediction queued is compared.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("seg",         mon_e.t, seg,                mon_e.seg);
      chk("an",          mon_e.t, {4'h0, an},         {4'h0, mon_e.an});
      chk("busy",        mon_e.t, {7'h0, busy},       {7'h0, mon_e.busy});
      chk("frame_start", mon_e.t, {7'h0, frame_start}, {7'h0, mon_e.fs});
    end
  end

  task automatic step(input logic r, input logic ld, input logic [15:0] v, input logic [3:0] d);
    exp_t e;
    if (r) begin
      e.seg = 8'hFF; e.an = 4'hF; e.busy = 1'b0; e.fs = 1'b0; e.t = -1;
      sb.push_back(e);
      mdl_t = 0;
      hist.delete();
    end else begin
      e = model(mdl_t);
      sb.push_back(e);
      if (ld) hist.push_back('{tgt: (mdl_t + 1) / FR + 1, v: v, d: d});
      mdl_t++;
    end
    rst   = r;
    load  = ld;
    value = v;
    dp    = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FR && (mdl_t % FR) != p; i++) step(1'b0, 1'b0, 16'h0, 4'h0);
  endtask

  initial begin
    logic        r, ld;
    logic [15:0] v;
    logic [3:0]  d;
    rst = 1'b1; load = 1'b0; value = '0; dp = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(10);
    step(1'b0, 1'b1, 16'h1A3F, 4'b0100);
    idle(70);
    wait_phase(5);
    step(1'b0, 1'b1, 16'h1111, 4'h0);
    idle(3);
    step(1'b0, 1'b1, 16'h2222, 4'h0);
    idle(70);
    wait_phase(FR - 1);
    step(1'b0, 1'b1, 16'h5555, 4'h0);
    idle(70);
    step(1'b0, 1'b1, 16'h0070, 4'h0);
    idle(70);
    step(1'b0, 1'b1, 16'h0000, 4'h0);
    idle(70);
    step(1'b0, 1'b1, 16'h0000, 4'b0100);
    idle(70);
    wait_phase(3);
    step(1'b0, 1'b1, 16'hBEEF, 4'b1001);
    wait_phase(18);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    idle(40);
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 249) == 0);
      ld = !r && ($urandom_range(0, 7) == 0);
      v  = 16'($urandom) >> ($urandom_range(0, 4) * 4);
      d  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      step(r, ld, v, d);
    end
    idle(40);
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
